vending_machine: RTL and testbench

VENDING_MACHINE -- requirements
Module: vending_machine

---
 rtl/vm_pkg.sv | 15 +
 rtl/vm_sale_counter.sv | 23 ++
 rtl/vending_machine.sv | 84 ++++++++
 tb/tb_vending_machine.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types for the vending machine: credit states and coin encodings.
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        ONE  = 2'd2
    } vm_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

endpackage

// File: rtl/vm_sale_counter.sv
// Wrapping count of shipped items; built only when VM_SALE_CNT_EN is defined.
module vm_sale_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/vending_machine.sv
// 1.5-unit vending FSM with registered shipping/change pulses.
// Optional sale counter port enabled by defining VM_SALE_CNT_EN.
module vending_machine
    import vm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       coin,
`ifdef VM_SALE_CNT_EN
    output logic [CNT_W-1:0] sale_cnt,
`endif
    output logic             change,
    output logic             shipping
);

    vm_state_t r_state;
    logic      r_shipping;
    logic      r_change;
    logic      w_sale;
    logic      w_change;

    // A sale completes when the coin lifts credit to 1.5 units or beyond.
    always_comb begin
        w_sale   = 1'b0;
        w_change = 1'b0;
        case (r_state)
            HALF: w_sale = (coin == COIN_ONE);
            ONE: begin
                w_sale   = (coin == COIN_HALF) || (coin == COIN_ONE);
                w_change = (coin == COIN_ONE);
            end
            default: begin
                w_sale   = 1'b0;
                w_change = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shipping <= 1'b0;
            r_change   <= 1'b0;
        end else begin
            r_shipping <= w_sale;
            r_change   <= w_change;
            case (r_state)
                IDLE: begin
                    if (coin == COIN_HALF)     r_state <= HALF;
                    else if (coin == COIN_ONE) r_state <= ONE;
                end
                HALF: begin
                    if (coin == COIN_HALF)     r_state <= ONE;
                    else if (coin == COIN_ONE) r_state <= IDLE;
                end
                ONE: begin
                    if ((coin == COIN_HALF) || (coin == COIN_ONE)) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign shipping = r_shipping;
    assign change   = r_change;

`ifdef VM_SALE_CNT_EN
    vm_sale_counter #(
        .CNT_W (CNT_W)
    ) u_sale_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_sale),
        .o_cnt (sale_cnt)
    );
`else
    // CNT_W has no effect without the counter; this keeps a bad value visible.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Bench for vending_machine: directed scenarios plus random coins and resets,
// checked against a credit-arithmetic reference model.
module tb_vending_machine;

    localparam int TB_CNT_W = 2;

    logic                clk;
    logic                rst_n;
    logic [1:0]          coin;
    logic                change;
    logic                shipping;
`ifdef VM_SALE_CNT_EN
    logic [TB_CNT_W-1:0] sale_cnt;
`endif

    int n_checks;
    int n_errors;
    int credit_halves;
    int sales;

    vending_machine #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .coin     (coin),
`ifdef VM_SALE_CNT_EN
        .sale_cnt (sale_cnt),
`endif
        .change   (change),
        .shipping (shipping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_ship, input logic exp_chg);
        check({tag, ".shipping"}, {31'd0, shipping}, {31'd0, exp_ship});
        check({tag, ".change"}, {31'd0, change}, {31'd0, exp_chg});
`ifdef VM_SALE_CNT_EN
        check({tag, ".sale_cnt"}, 32'(sale_cnt), 32'(sales % (1 << TB_CNT_W)));
`endif
    endtask

    // Drive one coin for one edge; model: credit in half units, price is 3 halves.
    task automatic apply(input string tag, input logic [1:0] c);
        logic exp_ship;
        logic exp_chg;
        coin = c;
        @(posedge clk);
        #1;
        exp_ship = 1'b0;
        exp_chg  = 1'b0;
        if (c == 2'b01) credit_halves += 1;
        else if (c == 2'b10) credit_halves += 2;
        if (credit_halves >= 3) begin
            exp_ship = 1'b1;
            exp_chg  = (credit_halves - 3) == 1;
            credit_halves = 0;
            sales++;
        end
        check_outputs(tag, exp_ship, exp_chg);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        credit_halves = 0;
        sales = 0;
        check_outputs(tag, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        credit_halves = 0;
        sales = 0;
        coin  = 2'b00;
        rst_n = 1'b0;
        #12;
        check_outputs("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three half coins
        apply("s1.c1", 2'b01);
        apply("s1.c2", 2'b01);
        apply("s1.c3", 2'b01);
        apply("s1.idle", 2'b00);
        // Two full coins, change returned
        apply("s2.c1", 2'b10);
        apply("s2.c2", 2'b10);
        apply("s2.idle", 2'b00);
        // Half then full, then full then half
        apply("s3.c1", 2'b01);
        apply("s3.c2", 2'b10);
        apply("s3.c3", 2'b10);
        apply("s3.c4", 2'b01);
        // Invalid and empty coins ignored
        apply("s4.c1", 2'b01);
        apply("s4.c2", 2'b11);
        apply("s4.c3", 2'b00);
        apply("s4.c4", 2'b01);
        apply("s4.c5", 2'b11);
        apply("s4.c6", 2'b01);
        apply("s4.idle", 2'b00);
        // Back-to-back completing coins
        apply("s5.c1", 2'b10);
        apply("s5.c2", 2'b10);
        apply("s5.c3", 2'b10);
        apply("s5.c4", 2'b10);
        // Reset while a shipping pulse is high, then credit discarded
        apply("s6.c1", 2'b01);
        apply("s6.c2", 2'b10);
        async_reset("s6.rst");
        apply("s7.c1", 2'b10);
        async_reset("s7.rst");
        apply("s7.c2", 2'b01);
        apply("s7.c3", 2'b10);
        // Five sales from reset: counter wraps through 1,2,3,0,1
        async_reset("s8.rst");
        for (int i = 0; i < 5; i++) begin
            apply("s8.a", 2'b01);
            apply("s8.b", 2'b10);
        end
        // Random coins with occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) async_reset("rnd.rst");
            apply("rnd", 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
